aes_decrypt_iter: RTL and testbench
===================================

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 SHALL have parameter: KEY_REUSE, 1, when 1 skip key expansion if the accepted key equals the cached key.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  ciphertext/key offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept a new job.
REQ-006 SHALL have port: key  input  128  AES-128 cipher key (round key 0), byte 0 = bits [127:120].
REQ-007 SHALL have port: data_in  input  128  ciphertext block, same byte order as key.
REQ-008 SHALL have port: out_valid  output  1  plaintext available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts plaintext.
REQ-010 SHALL have port: data_out  output  128  plaintext, FIPS-197 inverse cipher of data_in under key.

Function
REQ-011 SHALL be iterative: one shared InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns datapath, 16 inverse S-box and 4 forward S-box lookups (key schedule).
REQ-012 SHALL implement FSM states IDLE, KEYGEN, ADDKEY, ROUND, FINAL, DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, latch data_in into state reg and key into key reg.
REQ-014 From IDLE on accept: go to ADDKEY if KEY_REUSE=1, cache valid and key equals cached key (load cached rk10); otherwise go to KEYGEN with rcon=0x01.
REQ-015 KEYGEN: exactly 10 cycles, each advancing key reg one forward expansion step (rk1..rk10), rcon doubled in GF(2^8) (0x80 -> 0x1b); after 10th cycle store rk10 and key into cache, set cache valid, go to ADDKEY.
REQ-016 ADDKEY: 1 cycle; state <= state ^ rk10; key reg <= rk9 by inverse expansion; go to ROUND.
REQ-017 ROUND: exactly 9 cycles (r=9..1): state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_r)); key reg <= rk_(r-1).
REQ-018 Inverse expansion SHALL be: w0'=w0^SubWord(RotWord(w3^w2))^rcon_r, w1'=w1^w0, w2'=w2^w1, w3'=w3^w2, with rcon stepping backward 0x36 -> 0x01.
REQ-019 FINAL: 1 cycle; state <= InvSubBytes(InvShiftRows(state)) ^ rk0; go to DONE.
REQ-020 DONE: out_valid=1, data_out=state held stable until out_ready; on out_valid&&out_ready go to IDLE next cycle.
REQ-021 Latency, accept edge to first out_valid cycle: 21 cycles (KEYGEN path), 11 cycles (cache hit).
REQ-022 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE ignored, no job queued.
REQ-023 data_out SHALL be 0 whenever out_valid=0.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Cache compare SHALL use full 128-bit key; KEY_REUSE=0 forces KEYGEN every job and never marks the cache valid.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, data_out=0, cache invalid, clearing state, key and rcon regs, from any state including mid-KEYGEN/ROUND.
REQ-027 Job aborted by reset SHALL never produce out_valid; the first accept after rst deasserts SHALL run full KEYGEN.

Verification
REQ-028 key=000102030405060708090a0b0c0d0e0f, data_in=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> data_out=00112233445566778899aabbccddeeff, out_valid 21 cycles after accept.
REQ-029 key=2b7e151628aed2a6abf7158809cf4f3c, data_in=3925841d02dc09fbdc118597196a0b32 -> data_out=3243f6a8885a308d313198a2e0370734.
REQ-030 Back-to-back REQ-029 job with same key, KEY_REUSE=1 -> same plaintext, latency 11; KEY_REUSE=0 -> latency 21.
REQ-031 out_ready=0 for 5 cycles in DONE -> out_valid and data_out stable, in_ready=0, new in_valid ignored; out_ready=1 -> in_ready=1 the following cycle.
REQ-032 rst pulse at cycle 5 of ROUND -> out_valid=0, in_ready=1 next cycle; resubmitting REQ-028 job takes 21 cycles with correct plaintext.
REQ-033 Random keys/data against a reference model, random in_valid/out_ready stalls -> every output matches, no lost or duplicated jobs.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
//   Iterative AES-128 decryptor (FIPS-197 inverse cipher). A single shared
//   round datapath is reused for every round. The round keys are produced on
//   the fly: the cipher key is expanded forward to rk10, and then walked
//   backwards one round key per cycle. When KEY_REUSE=1, the block caches the
//   last expanded key. A job that uses the same key skips forward expansion.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   in_valid  : ciphertext/key offered       in_ready  : idle, can accept a job
//   key       : AES-128 key, byte 0 = [127:120]
//   data_in   : ciphertext block, same byte order as key
//   out_valid : plaintext available           out_ready : consumer takes plaintext
//   data_out  : plaintext, zero while out_valid is low
// -----------------------------------------------------------------------------
module aes_decrypt_iter #(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  typedef enum logic [2:0] {IDLE, KEYGEN, ADDKEY, ROUND, FINAL, DONE} fsm_t;

  // Byte 0x00 of each table sits in the top byte of the flat constant.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Walks rcon backwards: 0x36 -> 0x1b -> 0x80 -> 0x40 ... -> 0x01.
  function automatic logic [7:0] rcon_prev(input logic [7:0] r);
    return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

  // The state is column-major: byte 4c+r is row r, column c. Row r rotates
  // right by r columns.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] res;
    int src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        res[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*src -: 8]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   m11 [4];
    logic [7:0]   m13 [4];
    logic [7:0]   m14 [4];
    logic [7:0]   x2, x4, x8;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]   = s[127 - 8*(4*c + r) -: 8];
        x2     = xtime(a[r]);
        x4     = xtime(x2);
        x8     = xtime(x4);
        m9[r]  = x8 ^ a[r];
        m11[r] = x8 ^ x2 ^ a[r];
        m13[r] = x8 ^ x4 ^ a[r];
        m14[r] = x8 ^ x4 ^ x2;
      end
      res[127 - 32*c -: 32] = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                               m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                               m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                               m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    end
    return res;
  endfunction

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;
  logic         r_cache_vld;
  logic [127:0] r_cache_key;
  logic [127:0] r_cache_rk10;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_data_out;

  // Round datapath
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_isb = inv_shift_sub(r_state);
  assign w_ark = w_isb ^ r_key;
  assign w_imc = inv_mix_columns(w_ark);

  // Key schedule. The forward step and the inverse step share the four S-boxes.
  // The forward step substitutes w3. The inverse step substitutes the
  // recovered previous w3, which is w3 ^ w2.
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_sub_src, w_sub, w_new0;
  logic [127:0] w_key_fwd, w_key_inv;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_sub_src = (r_fsm == KEYGEN) ? w_w3 : (w_w3 ^ w_w2);
  assign w_sub     = {sbox(w_sub_src[23:16]), sbox(w_sub_src[15:8]),
                      sbox(w_sub_src[7:0]),   sbox(w_sub_src[31:24])};
  assign w_new0    = w_w0 ^ w_sub ^ {r_rcon, 24'h0};
  assign w_key_fwd = {w_new0, w_new0 ^ w_w1, w_new0 ^ w_w1 ^ w_w2,
                      w_new0 ^ w_w1 ^ w_w2 ^ w_w3};
  assign w_key_inv = {w_new0, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

  logic w_accept, w_cache_hit;
  assign w_accept    = (r_fsm == IDLE) && in_valid;
  assign w_cache_hit = KEY_REUSE && r_cache_vld && (key == r_cache_key);

  // NOTE: sequential state is only ever written with <=. A blocking write
  // here would let later statements in the same edge see the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_key       <= '0;
      r_rcon      <= '0;
      r_cnt       <= '0;
      r_cache_vld <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state    <= data_in;
            r_in_ready <= 1'b0;
            if (w_cache_hit) begin
              r_key  <= r_cache_rk10;
              r_rcon <= 8'h36;
              r_fsm  <= ADDKEY;
            end else begin
              // The cache key is overwritten at this point, so the cache
              // stays invalid until this expansion finishes.
              r_cache_vld <= 1'b0;
              r_key       <= key;
              r_rcon      <= 8'h01;
              r_cnt       <= '0;
              r_fsm       <= KEYGEN;
            end
          end
        end
        KEYGEN: begin
          r_key <= w_key_fwd;
          if (r_cnt == 4'd9) begin
            // rcon stays at 0x36. That is the first value the backward walk needs.
            r_cache_vld <= KEY_REUSE;
            r_fsm       <= ADDKEY;
          end else begin
            r_rcon <= xtime(r_rcon);
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        ADDKEY: begin
          r_state <= r_state ^ r_key;
          r_key   <= w_key_inv;
          r_rcon  <= rcon_prev(r_rcon);
          r_cnt   <= '0;
          r_fsm   <= ROUND;
        end
        ROUND: begin
          r_state <= w_imc;
          r_key   <= w_key_inv;
          r_rcon  <= rcon_prev(r_rcon);
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd8) r_fsm <= FINAL;
        end
        FINAL: begin
          r_state     <= w_ark;
          r_data_out  <= w_ark;
          r_out_valid <= 1'b1;
          r_fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_in_ready  <= 1'b1;
            r_fsm       <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  // NOTE: the cache contents are deliberately left out of reset. Only the
  // valid bit is reset, and it decides whether the cached data is trusted.
  always_ff @(posedge clk) begin
    if (w_accept && !w_cache_hit) r_cache_key <= key;
    if (r_fsm == KEYGEN && r_cnt == 4'd9) r_cache_rk10 <= w_key_fwd;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decrypt_iter
//   Directed bench for aes_decrypt_iter. The expected values are published
//   AES-128 known answers: the FIPS-197 examples, the SP 800-38A ECB vectors
//   and the all-zero key/plaintext. One instance runs with key caching
//   (dut) and one without it (dut0).
// -----------------------------------------------------------------------------
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_valid0 = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] data_i = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, in_ready0, out_valid0;
  logic [127:0] data_out, data_out0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_B1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_B2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT_B2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_B3 = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] PT_B3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT_B4 = 128'h7b0c785e27e8ad3f8223207104725dd4;
  localparam logic [127:0] PT_B4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_decrypt_iter #(.KEY_REUSE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key_i), .data_in(data_i), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out)
  );

  aes_decrypt_iter #(.KEY_REUSE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .key(key_i), .data_in(data_i), .out_valid(out_valid0),
    .out_ready(out_ready), .data_out(data_out0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the chosen DUT to be ready, then offers one job. The task
  // returns 1 ns after the accept edge.
  task automatic accept(input bit sel, input logic [127:0] k, input logic [127:0] d,
                        input string tag, output bit ok);
    int w = 0;
    @(negedge clk);
    while (!(sel ? in_ready0 : in_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = sel ? in_ready0 : in_ready;
    check({tag, "_ready"}, ok, 1'b1);
    if (ok) begin
      key_i  = k;
      data_i = d;
      if (sel) in_valid0 = 1'b1; else in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_valid0 = 1'b0;
    end
  endtask

  // Runs one job. It checks the latency and the outputs while the job is busy.
  // It checks the plaintext when chk is set. A nonzero hold keeps out_ready
  // low for that many cycles in DONE while a new job is offered.
  task automatic job(input bit sel, input logic [127:0] k, input logic [127:0] d,
                     input logic [127:0] exp, input bit chk, input int lat,
                     input int hold, input string tag);
    bit           ok, ov, busy_ok, zero_ok, stable_ok, quiet_ok;
    int           n;
    logic [127:0] held;
    accept(sel, k, d, tag, ok);
    if (!ok) return;
    if (hold > 0) out_ready = 1'b0;
    n = 0; ov = 1'b0; busy_ok = 1'b1; zero_ok = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      ov = sel ? out_valid0 : out_valid;
      if (!ov) begin
        if ((sel ? in_ready0 : in_ready) !== 1'b0) busy_ok = 1'b0;
        if ((sel ? data_out0 : data_out) !== '0) zero_ok = 1'b0;
      end
    end while (!ov && n < 100);
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_not_ready"}, busy_ok, 1'b1);
    check({tag, "_data_zero_while_invalid"}, zero_ok, 1'b1);
    if (!ov) begin
      out_ready = 1'b1;
      return;
    end
    held = sel ? data_out0 : data_out;
    if (chk) check({tag, "_plaintext"}, held, exp);
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        key_i = ~k; data_i = ~d;
        if (sel) in_valid0 = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if ((sel ? out_valid0 : out_valid) !== 1'b1) stable_ok = 1'b0;
        if ((sel ? data_out0 : data_out) !== held) stable_ok = 1'b0;
        if ((sel ? in_ready0 : in_ready) !== 1'b0) stable_ok = 1'b0;
      end
      in_valid = 1'b0; in_valid0 = 1'b0;
      check({tag, "_stall_stable"}, stable_ok, 1'b1);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pop_valid"}, sel ? out_valid0 : out_valid, 1'b0);
    check({tag, "_pop_ready"}, sel ? in_ready0 : in_ready, 1'b1);
    check({tag, "_pop_data"}, sel ? data_out0 : data_out, '0);
    if (hold > 0) begin
      // The job offered during the stall must not have been queued.
      quiet_ok = 1'b1;
      repeat (30) begin
        @(negedge clk);
        if ((sel ? out_valid0 : out_valid) !== 1'b0) quiet_ok = 1'b0;
      end
      check({tag, "_no_phantom_job"}, quiet_ok, 1'b1);
    end
  endtask

  initial begin
    bit ok;
    bit quiet;

    // Reset state of both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_in_ready_nr", in_ready0, 1'b1);
    check("rst_out_valid_nr", out_valid0, 1'b0);
    rst = 1'b0;

    // Caching instance
    job(1'b0, KEY_A, CT_A, PT_A, 1'b1, 21, 0, "fips_c1");
    job(1'b0, KEY_B, CT_B, PT_B, 1'b1, 21, 0, "fips_b_miss");
    job(1'b0, KEY_B, CT_B, PT_B, 1'b1, 11, 0, "fips_b_hit");
    job(1'b0, KEY_B, CT_B1, PT_B1, 1'b1, 11, 0, "ecb1_hit");
    job(1'b0, KEY_B, CT_B2, PT_B2, 1'b1, 11, 5, "ecb2_stall");
    job(1'b0, '0, CT_Z, '0, 1'b1, 21, 0, "zero_key");
    // A key that differs only in its last bit must miss the cache. Its
    // plaintext is not a published value, so only the latency is checked.
    job(1'b0, KEY_B ^ 128'h1, CT_B3, '0, 1'b0, 21, 0, "key_lsb_flip");
    job(1'b0, KEY_B, CT_B3, PT_B3, 1'b1, 21, 0, "ecb3_after_flip");

    // No-cache instance: every job expands the key.
    job(1'b1, KEY_B, CT_B, PT_B, 1'b1, 21, 0, "nr_b1");
    job(1'b1, KEY_B, CT_B, PT_B, 1'b1, 21, 0, "nr_b2");
    job(1'b1, KEY_B, CT_B4, PT_B4, 1'b1, 21, 0, "nr_ecb4");

    // Reset in the middle of ROUND. KEY_A is cached, so the job follows the
    // hit path. Edge 6 after accept is the fifth ROUND cycle.
    job(1'b0, KEY_A, CT_A, PT_A, 1'b1, 21, 0, "fips_c1_again");
    accept(1'b0, KEY_A, CT_A, "abort", ok);
    if (ok) begin
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_data_out", data_out, '0);
      quiet = 1'b1;
      repeat (25) begin
        @(negedge clk);
        if (out_valid !== 1'b0) quiet = 1'b0;
      end
      check("abort_no_output", quiet, 1'b1);
    end
    // The reset invalidated the cache, so this job runs the full expansion.
    job(1'b0, KEY_A, CT_A, PT_A, 1'b1, 21, 0, "after_rst_miss");
    job(1'b0, KEY_A, CT_A, PT_A, 1'b1, 11, 0, "after_rst_hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
